// File: rtl/mem_loader.sv
// Framed byte-stream loader: writes 16-bit words into cell memory, verifies the
// XOR checksum, then pulses start with the expression address.
module mem_loader #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              core_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              start,
    output logic [ADDR_W-1:0] expr_addr,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              loading
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_COUNT, S_EXPR, S_HI, S_LO, S_CHK
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] expr_pending;
    logic [7:0]        remain;
    logic [7:0]        hi;
    logic [7:0]        chk;
    logic              nil_hit;
    logic [TW-1:0]     tcnt;
    logic              timeout;
    logic              xfer;

    assign timeout = loading && (tcnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        in_ready = 1'b0;
        if (state == S_IDLE) in_ready = ~core_busy;
        else                 in_ready = ~timeout;
    end

    assign xfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            expr_pending <= '0;
            remain       <= '0;
            hi           <= '0;
            chk          <= '0;
            nil_hit      <= 1'b0;
            tcnt         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            start        <= 1'b0;
            expr_addr    <= '0;
            frame_ok     <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= '0;
            loading      <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            start     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (timeout) begin
                state     <= S_IDLE;
                loading   <= 1'b0;
                frame_err <= 1'b1;
                err_code  <= 2'd2;
                tcnt      <= '0;
            end else begin
                if (loading) tcnt <= xfer ? '0 : tcnt + 1'b1;
                if (xfer) begin
                    unique case (state)
                        S_IDLE: begin
                            if (in_data == HEADER) begin
                                state   <= S_ADDR;
                                loading <= 1'b1;
                                nil_hit <= 1'b0;
                                tcnt    <= '0;
                            end
                        end
                        S_ADDR: begin
                            ptr   <= in_data[ADDR_W-1:0];
                            chk   <= in_data;
                            state <= S_COUNT;
                        end
                        S_COUNT: begin
                            remain <= in_data;
                            chk    <= chk ^ in_data;
                            state  <= S_EXPR;
                        end
                        S_EXPR: begin
                            // EXPR is always on the wire; an empty frame skips only the data phase
                            expr_pending <= in_data[ADDR_W-1:0];
                            chk          <= chk ^ in_data;
                            state        <= (remain == 8'd0) ? S_CHK : S_HI;
                        end
                        S_HI: begin
                            hi    <= in_data;
                            chk   <= chk ^ in_data;
                            state <= S_LO;
                        end
                        S_LO: begin
                            chk       <= chk ^ in_data;
                            mem_addr  <= ptr;
                            mem_wdata <= {hi, in_data};
                            if (ptr == '0) begin
                                nil_hit  <= 1'b1;
                                err_code <= 2'd3;
                            end else begin
                                mem_we <= 1'b1;
                            end
                            ptr    <= ptr + 1'b1;
                            remain <= remain - 8'd1;
                            state  <= (remain == 8'd1) ? S_CHK : S_HI;
                        end
                        S_CHK: begin
                            state   <= S_IDLE;
                            loading <= 1'b0;
                            if (chk != in_data) begin
                                frame_err <= 1'b1;
                                err_code  <= 2'd1;
                            end else if (nil_hit) begin
                                frame_err <= 1'b1;
                            end else begin
                                frame_ok  <= 1'b1;
                                start     <= 1'b1;
                                expr_addr <= expr_pending;
                                err_code  <= 2'd0;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: table frames, random frames against a frame-level
// model, and hand-written timeout / busy / reset / stray-byte sequences.
module tb_mem_loader;
    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        core_busy;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        start;
    logic [7:0]  expr_addr;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        loading;

    mem_loader #(.ADDR_W(8), .TIMEOUT_CYCLES(TO), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .core_busy(core_busy), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .start(start),
        .expr_addr(expr_addr), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code), .loading(loading)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [23:0] wr_q[$];
    int unsigned ok_cnt, err_cnt, start_cnt;
    logic [7:0]  m_expr = 8'h00;
    logic [1:0]  m_code = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
            if (frame_ok) ok_cnt++;
            if (frame_err) err_cnt++;
            if (start) begin
                start_cnt++;
                check("start_with_ok", frame_ok, 1);
            end
            if (frame_ok || frame_err) check("loading_drops_with_pulse", loading, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit must_ready);
        int unsigned n = 0;
        in_data  = b;
        in_valid = 1'b1;
        #1;
        if (must_ready) check("ready_mid_frame", in_ready, 1);
        while (!in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) check("handshake_bound", 0, 1);
        else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] n, input logic [7:0] e,
                             input logic [15:0] w [8], input logic [7:0] flip_mask,
                             input bit busy_hdr, input bit stray);
        logic [7:0]  bytes[$];
        logic [23:0] exp_w[$];
        logic [7:0]  c;
        logic [7:0]  wa;
        bit          nil;
        bit          ok;
        bytes = {a, n, e};
        for (int i = 0; i < int'(n); i++) begin
            bytes.push_back(w[i][15:8]);
            bytes.push_back(w[i][7:0]);
        end
        c = 8'h00;
        foreach (bytes[i]) c = c ^ bytes[i];
        bytes.push_back(c ^ flip_mask);
        nil = 0;
        for (int i = 0; i < int'(n); i++) begin
            wa = a + 8'(i);
            if (wa == 8'h00) nil = 1;
            else exp_w.push_back({wa, w[i]});
        end
        ok = (flip_mask == 8'h00) && !nil;
        if (ok) begin
            m_code = 2'd0;
            m_expr = e;
        end else begin
            m_code = (flip_mask != 8'h00) ? 2'd1 : 2'd3;
        end

        wr_q.delete();
        ok_cnt = 0; err_cnt = 0; start_cnt = 0;
        core_busy = 1'b0;
        if (stray) begin
            send_byte(8'h3C, 0);
            check("stray_dropped", loading, 0);
        end
        if (busy_hdr) begin
            core_busy = 1'b1;
            in_data   = 8'hA5;
            in_valid  = 1'b1;
            repeat (4) begin
                @(negedge clk); #1;
                check("busy_blocks_ready", in_ready, 0);
            end
            check("busy_no_load", loading, 0);
            core_busy = 1'b0;
        end
        send_byte(8'hA5, 0);
        check("loading_set", loading, 1);
        foreach (bytes[i]) begin
            core_busy = 1'($urandom_range(0, 1));
            send_byte(bytes[i], 1);
        end
        in_valid  = 1'b0;
        core_busy = 1'b0;
        repeat (3) @(negedge clk);

        check("wr_count", wr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            check("wr_addr_data", wr_q[i], exp_w[i]);
        check("ok_count", ok_cnt, ok ? 1 : 0);
        check("err_count", err_cnt, ok ? 0 : 1);
        check("start_count", start_cnt, ok ? 1 : 0);
        check("err_code", err_code, m_code);
        check("expr_addr", expr_addr, m_expr);
        check("loading_end", loading, 0);
    endtask

    typedef struct {
        logic [7:0]  a, n, e;
        logic [15:0] w [8];
        logic [7:0]  flip;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vt[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w [8];
        int unsigned n;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; core_busy = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {mem_we, start, frame_ok, frame_err, loading}, 0);
        check("rst_err_expr", {err_code, expr_addr}, 0);
        core_busy = 1'b1; #1;
        check("rst_in_ready_busy", in_ready, 0);
        core_busy = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            vt[i].w = '{default: 16'h0};
            vt[i].flip = 8'h00;
        end
        vt[0].a = 8'h01; vt[0].n = 8'd3; vt[0].e = 8'h0F;
        vt[0].w[0] = 16'h0000; vt[0].w[1] = 16'h0005; vt[0].w[2] = 16'h0002; vt[0].exp_code = 2'd0;
        vt[1] = vt[0]; vt[1].flip = 8'h01; vt[1].exp_code = 2'd1;
        vt[2].a = 8'hFF; vt[2].n = 8'd2; vt[2].e = 8'h33;
        vt[2].w[0] = 16'h1234; vt[2].w[1] = 16'hABCD; vt[2].exp_code = 2'd3;
        vt[3].a = 8'hFE; vt[3].n = 8'd2; vt[3].e = 8'h44;
        vt[3].w[0] = 16'hA5A5; vt[3].w[1] = 16'h00A5; vt[3].exp_code = 2'd0;
        vt[4].a = 8'h10; vt[4].n = 8'd0; vt[4].e = 8'h20; vt[4].exp_code = 2'd0;

        for (int i = 0; i < 5; i++) begin
            run_frame(vt[i].a, vt[i].n, vt[i].e, vt[i].w, vt[i].flip, 0, 0);
            check("table_err_code", err_code, vt[i].exp_code);
        end

        // timeout after COUNT
        send_byte(8'hA5, 0);
        send_byte(8'h10, 1);
        send_byte(8'h02, 1);
        in_valid = 1'b0;
        n = 0;
        while (!frame_err && n < TO + 20) begin
            @(negedge clk); n++;
        end
        check("timeout_seen", frame_err, 1);
        check("timeout_not_early", n >= TO, 1);
        check("timeout_not_late", n <= TO + 2, 1);
        check("timeout_code", err_code, 2);
        check("timeout_loading", loading, 0);
        m_code = 2'd2;
        @(negedge clk); #1;
        check("timeout_idle_ready", in_ready, 1);
        w = '{16'h0101, 16'h0202, 16'h0303, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame(8'h40, 8'd3, 8'h55, w, 8'h00, 0, 0);

        // error frame leaves err_code set, then reset mid-data
        run_frame(8'h40, 8'd1, 8'h66, w, 8'h80, 0, 0);
        wr_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h05, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        send_byte(8'h12, 1);
        in_valid = 1'b0;
        rst = 1'b0; #1;
        check("midrst_outputs", {mem_we, start, frame_ok, frame_err, loading}, 0);
        check("midrst_err_expr", {err_code, expr_addr}, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_write", wr_q.size(), 0);
        m_code = 2'd0; m_expr = 8'h00;

        run_frame(8'h01, 8'd1, 8'h22, w, 8'h00, 1, 0);
        run_frame(8'h08, 8'd2, 8'h77, w, 8'h00, 0, 1);

        for (int k = 0; k < 20; k++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a = 8'hFC + 8'($urandom_range(0, 3));
            for (int j = 0; j < 8; j++) w[j] = 16'($urandom);
            run_frame(a, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), w,
                      ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                      0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
